bpd_update_serializer: RTL and testbench
========================================

BPD_UPDATE_SERIALIZER -- requirements
Module: bpd_update_serializer

Interface
REQ-001 SHALL provide parameters: none; all widths are fixed as listed below.
REQ-002 SHALL have one clock and one reset: clock is the single clock, and reset is synchronous and active-high.
REQ-003 SHALL have these ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous active-high reset.
- io_flush  in  1  discard all buffered and in-flight updates.
- io_in_valid  in  1  update offered.
- io_in_ready  out  1  update accepted when valid&ready.
- io_in_bits_is_mispredict_update  in  1.
- io_in_bits_is_repair_update  in  1.
- io_in_bits_btb_mispredicts  in  8.
- io_in_bits_pc  in  40.
- io_in_bits_br_mask  in  8.
- io_in_bits_cfi_idx_valid  in  1.
- io_in_bits_cfi_idx_bits  in  3.
- io_in_bits_cfi_taken / cfi_mispredicted / cfi_is_br / cfi_is_jal  in  1 each.
- io_in_bits_ghist_old_history  in  64.
- io_in_bits_ghist_new_saw_branch_not_taken / _taken  in  1 each.
- io_in_bits_target  in  40.
- io_in_bits_meta_0, io_in_bits_meta_1  in  120 each, per-bank predictor metadata.
- io_out_valid  out  1  beat offered to predictor banks.
- io_out_ready  in  1  beat consumed when valid&ready.
- io_out_bits_<all io_in_bits fields except meta_0/meta_1>  out  same widths.
- io_out_bits_meta  out  120  metadata for the current beat.
- io_out_bits_bank  out  1  0 = meta_0 beat, 1 = meta_1 beat.
- io_out_bits_last  out  1  high on the bank-1 beat.
- io_count  out  2  number of buffered updates, 0..2.

Function
REQ-004 SHALL buffer updates in a 2-entry FIFO with head/tail pointers and a count register.
REQ-005 SHALL drive io_in_ready = (count != 2) & ~io_flush, with no combinational dependence on io_out_ready.
REQ-006 SHALL write an accepted update into the tail entry and increment tail, mod 2.
REQ-007 SHALL present an accepted update on io_out no earlier than the cycle after acceptance; there is no flow-through path.
REQ-008 SHALL drive io_out_valid = (count != 0).
REQ-009 SHALL serialize each head entry into exactly two beats, driven by a beat register with states BEAT0 and BEAT1.
- BEAT0: bank = 0, meta = meta_0, last = 0.
- BEAT1: bank = 1, meta = meta_1, last = 1.
REQ-010 SHALL drive all non-meta io_out_bits fields from the head entry, identically on both beats.
REQ-011 SHALL handle handshakes in the beat FSM as follows:
- On an io_out handshake in BEAT0, move to BEAT1.
- On an io_out handshake in BEAT1, pop the head: head+1 mod 2, count-1, return to BEAT0.
- Without a handshake, hold state and all outputs stable.
REQ-012 SHALL, when an enqueue and a BEAT1 pop occur in the same cycle, leave count unchanged and update both pointers.
REQ-013 SHALL, when count == 2, keep io_in_ready low, including during the cycle of a BEAT1 pop.
REQ-014 SHALL give io_flush priority over all other events: the next cycle has count = 0, head = tail = 0, beat = BEAT0, and any concurrent io_in handshake is impossible because ready is low.
REQ-015 SHALL not reorder updates: beats leave in acceptance order, with bank 0 before bank 1 for each update.
REQ-016 SHALL leave io_out_bits don't-care when io_out_valid = 0; the bench SHALL NOT check them then.

Reset
REQ-017 SHALL, on reset asserted at a rising edge, make count = 0, head = tail = 0, beat = BEAT0 in the next cycle, giving io_out_valid = 0, io_in_ready = 1 and io_count = 0.
REQ-018 SHALL, when reset asserts mid-transfer, drop any buffered or half-sent update; no further beat of that update is emitted.
REQ-019 SHALL clear no buffer data storage on reset; only control state is reset.

Verification
REQ-020 Single update: pc = 0x80000040, meta_0 = A, meta_1 = B, io_out_ready held 1 -> cycle+1 beat {bank 0, meta A, last 0}, cycle+2 beat {bank 1, meta B, last 1}, pc = 0x80000040 on both beats, io_count returns to 0.
REQ-021 Backpressure: offer 3 updates with io_out_ready = 0 -> first two accepted, io_count = 2, io_in_ready = 0 on the third; raising io_out_ready drains 4 beats in order U0b0, U0b1, U1b0, U1b1, then U2 is accepted.
REQ-022 Stall mid-update: drop io_out_ready after the BEAT0 handshake for 5 cycles -> the bank-1 beat is held stable with all fields unchanged, then completes.
REQ-023 Simultaneous events: with count = 1 in BEAT1, enqueue and handshake in the same cycle -> count stays 1, the next beat is the new update's bank 0.
REQ-024 Flush: with count = 2 in BEAT1, assert io_flush for 1 cycle -> next cycle io_out_valid = 0, io_count = 0, io_in_ready = 1; a following update starts at bank 0.
REQ-025 Reset mid-operation: assert reset while count = 2 -> next cycle io_out_valid = 0, io_count = 0, and no stale beats appear after reset deasserts.

Source files
------------

// File: rtl/bpd_update_serializer.sv
// Two-entry update FIFO that replays each buffered branch-predictor update as two beats,
// bank 0 metadata first and then bank 1, with the shared fields repeated on both beats.
module bpd_update_serializer (
  input  logic         clock,
  input  logic         reset,
  input  logic         io_flush,
  input  logic         io_in_valid,
  output logic         io_in_ready,
  input  logic         io_in_bits_is_mispredict_update,
  input  logic         io_in_bits_is_repair_update,
  input  logic [7:0]   io_in_bits_btb_mispredicts,
  input  logic [39:0]  io_in_bits_pc,
  input  logic [7:0]   io_in_bits_br_mask,
  input  logic         io_in_bits_cfi_idx_valid,
  input  logic [2:0]   io_in_bits_cfi_idx_bits,
  input  logic         io_in_bits_cfi_taken,
  input  logic         io_in_bits_cfi_mispredicted,
  input  logic         io_in_bits_cfi_is_br,
  input  logic         io_in_bits_cfi_is_jal,
  input  logic [63:0]  io_in_bits_ghist_old_history,
  input  logic         io_in_bits_ghist_new_saw_branch_not_taken,
  input  logic         io_in_bits_ghist_new_saw_branch_taken,
  input  logic [39:0]  io_in_bits_target,
  input  logic [119:0] io_in_bits_meta_0,
  input  logic [119:0] io_in_bits_meta_1,
  output logic         io_out_valid,
  input  logic         io_out_ready,
  output logic         io_out_bits_is_mispredict_update,
  output logic         io_out_bits_is_repair_update,
  output logic [7:0]   io_out_bits_btb_mispredicts,
  output logic [39:0]  io_out_bits_pc,
  output logic [7:0]   io_out_bits_br_mask,
  output logic         io_out_bits_cfi_idx_valid,
  output logic [2:0]   io_out_bits_cfi_idx_bits,
  output logic         io_out_bits_cfi_taken,
  output logic         io_out_bits_cfi_mispredicted,
  output logic         io_out_bits_cfi_is_br,
  output logic         io_out_bits_cfi_is_jal,
  output logic [63:0]  io_out_bits_ghist_old_history,
  output logic         io_out_bits_ghist_new_saw_branch_not_taken,
  output logic         io_out_bits_ghist_new_saw_branch_taken,
  output logic [39:0]  io_out_bits_target,
  output logic [119:0] io_out_bits_meta,
  output logic         io_out_bits_bank,
  output logic         io_out_bits_last,
  output logic [1:0]   io_count
);

  typedef enum logic {BEAT0 = 1'b0, BEAT1 = 1'b1} beat_t;

  beat_t          r_beat;
  beat_t          w_beat_nxt;
  logic           r_head;
  logic           r_tail;
  logic [1:0]     r_count;
  logic [1:0]     w_count_nxt;
  logic           w_in_fire;
  logic           w_out_fire;
  logic           w_pop;
  logic [171:0]   w_in_payload;
  logic [171:0]   w_head_payload;

  logic [171:0]   r_payload [0:1];
  logic [119:0]   r_meta0   [0:1];
  logic [119:0]   r_meta1   [0:1];

  // Everything except the per-bank metadata is stored as one packed word.
  assign w_in_payload = {io_in_bits_is_mispredict_update, io_in_bits_is_repair_update,
                         io_in_bits_btb_mispredicts, io_in_bits_pc, io_in_bits_br_mask,
                         io_in_bits_cfi_idx_valid, io_in_bits_cfi_idx_bits,
                         io_in_bits_cfi_taken, io_in_bits_cfi_mispredicted,
                         io_in_bits_cfi_is_br, io_in_bits_cfi_is_jal,
                         io_in_bits_ghist_old_history,
                         io_in_bits_ghist_new_saw_branch_not_taken,
                         io_in_bits_ghist_new_saw_branch_taken, io_in_bits_target};

  assign io_in_ready  = (r_count != 2'd2) & ~io_flush;
  assign io_out_valid = (r_count != 2'd0);
  assign io_count     = r_count;

  assign w_in_fire  = io_in_valid & io_in_ready;
  assign w_out_fire = io_out_valid & io_out_ready;
  assign w_pop      = w_out_fire & (r_beat == BEAT1);

  always_comb begin
    w_beat_nxt = r_beat;
    if (w_out_fire) begin
      w_beat_nxt = (r_beat == BEAT0) ? BEAT1 : BEAT0;
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_in_fire, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Flush shares the reset path so it wins over any concurrent pop or beat advance.
  always_ff @(posedge clock) begin
    if (reset || io_flush) begin
      r_beat <= BEAT0;
    end else begin
      r_beat <= w_beat_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || io_flush) begin
      r_count <= 2'd0;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (w_in_fire) r_tail <= ~r_tail;
      if (w_pop)     r_head <= ~r_head;
    end
  end

  // Storage is never reset; validity is carried entirely by r_count.
  always_ff @(posedge clock) begin
    if (w_in_fire) begin
      r_payload[r_tail] <= w_in_payload;
      r_meta0[r_tail]   <= io_in_bits_meta_0;
      r_meta1[r_tail]   <= io_in_bits_meta_1;
    end
  end

  assign w_head_payload = r_payload[r_head];

  assign {io_out_bits_is_mispredict_update, io_out_bits_is_repair_update,
          io_out_bits_btb_mispredicts, io_out_bits_pc, io_out_bits_br_mask,
          io_out_bits_cfi_idx_valid, io_out_bits_cfi_idx_bits,
          io_out_bits_cfi_taken, io_out_bits_cfi_mispredicted,
          io_out_bits_cfi_is_br, io_out_bits_cfi_is_jal,
          io_out_bits_ghist_old_history,
          io_out_bits_ghist_new_saw_branch_not_taken,
          io_out_bits_ghist_new_saw_branch_taken, io_out_bits_target} = w_head_payload;

  assign io_out_bits_meta = (r_beat == BEAT1) ? r_meta1[r_head] : r_meta0[r_head];
  assign io_out_bits_bank = (r_beat == BEAT1);
  assign io_out_bits_last = (r_beat == BEAT1);

endmodule

// File: tb/tb_bpd_update_serializer.sv
// Scoreboard bench: every accepted update queues its two expected beats; a monitor checks
// the output stream, occupancy and ready against that queue every cycle.
module tb_bpd_update_serializer;

  logic         clock = 1'b0;
  logic         reset;
  logic         io_flush;
  logic         io_in_valid;
  logic         io_in_ready;
  logic         in_is_mis, in_is_rep;
  logic [7:0]   in_btb;
  logic [39:0]  in_pc;
  logic [7:0]   in_brm;
  logic         in_cv;
  logic [2:0]   in_cb;
  logic         in_ct, in_cm, in_cbr, in_cj;
  logic [63:0]  in_gh;
  logic         in_gnt, in_gt;
  logic [39:0]  in_tgt;
  logic [119:0] in_m0, in_m1;
  logic         io_out_valid;
  logic         io_out_ready;
  logic         out_is_mis, out_is_rep;
  logic [7:0]   out_btb;
  logic [39:0]  out_pc;
  logic [7:0]   out_brm;
  logic         out_cv;
  logic [2:0]   out_cb;
  logic         out_ct, out_cm, out_cbr, out_cj;
  logic [63:0]  out_gh;
  logic         out_gnt, out_gt;
  logic [39:0]  out_tgt;
  logic [119:0] out_meta;
  logic         out_bank, out_last;
  logic [1:0]   io_count;

  always #5 clock = ~clock;

  bpd_update_serializer dut (
    .clock(clock), .reset(reset), .io_flush(io_flush),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_bits_is_mispredict_update(in_is_mis), .io_in_bits_is_repair_update(in_is_rep),
    .io_in_bits_btb_mispredicts(in_btb), .io_in_bits_pc(in_pc), .io_in_bits_br_mask(in_brm),
    .io_in_bits_cfi_idx_valid(in_cv), .io_in_bits_cfi_idx_bits(in_cb),
    .io_in_bits_cfi_taken(in_ct), .io_in_bits_cfi_mispredicted(in_cm),
    .io_in_bits_cfi_is_br(in_cbr), .io_in_bits_cfi_is_jal(in_cj),
    .io_in_bits_ghist_old_history(in_gh),
    .io_in_bits_ghist_new_saw_branch_not_taken(in_gnt),
    .io_in_bits_ghist_new_saw_branch_taken(in_gt),
    .io_in_bits_target(in_tgt), .io_in_bits_meta_0(in_m0), .io_in_bits_meta_1(in_m1),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_bits_is_mispredict_update(out_is_mis), .io_out_bits_is_repair_update(out_is_rep),
    .io_out_bits_btb_mispredicts(out_btb), .io_out_bits_pc(out_pc), .io_out_bits_br_mask(out_brm),
    .io_out_bits_cfi_idx_valid(out_cv), .io_out_bits_cfi_idx_bits(out_cb),
    .io_out_bits_cfi_taken(out_ct), .io_out_bits_cfi_mispredicted(out_cm),
    .io_out_bits_cfi_is_br(out_cbr), .io_out_bits_cfi_is_jal(out_cj),
    .io_out_bits_ghist_old_history(out_gh),
    .io_out_bits_ghist_new_saw_branch_not_taken(out_gnt),
    .io_out_bits_ghist_new_saw_branch_taken(out_gt),
    .io_out_bits_target(out_tgt), .io_out_bits_meta(out_meta),
    .io_out_bits_bank(out_bank), .io_out_bits_last(out_last), .io_count(io_count)
  );

  wire [171:0] w_in_pl  = {in_is_mis, in_is_rep, in_btb, in_pc, in_brm, in_cv, in_cb,
                           in_ct, in_cm, in_cbr, in_cj, in_gh, in_gnt, in_gt, in_tgt};
  wire [171:0] w_out_pl = {out_is_mis, out_is_rep, out_btb, out_pc, out_brm, out_cv, out_cb,
                           out_ct, out_cm, out_cbr, out_cj, out_gh, out_gnt, out_gt, out_tgt};

  typedef struct packed {
    logic [171:0] pl;
    logic [119:0] meta;
    logic         bank;
    logic         last;
  } beat_s;

  beat_s exp_q[$];
  int    total = 0;
  int    bad   = 0;
  logic  mon_en = 1'b0;
  logic  last_acc = 1'b0;

  task automatic chk(input string nm, input logic [171:0] act, input logic [171:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: occupancy/ready derived from the number of outstanding beats, then the
  // presented beat must equal the oldest outstanding beat every cycle it is valid.
  always @(negedge clock) begin
    int    n;
    beat_s e;
    if (mon_en) begin
      n = (exp_q.size() + 1) / 2;
      chk("io_count", 172'(io_count), 172'(n));
      chk("out_valid", 172'(io_out_valid), 172'(n != 0));
      chk("in_ready", 172'(io_in_ready), 172'((n != 2) && !io_flush));
      if (io_out_valid && exp_q.size() > 0) begin
        e = exp_q[0];
        chk("beat_fields", w_out_pl, e.pl);
        chk("beat_meta", 172'(out_meta), 172'(e.meta));
        chk("beat_bank_last", 172'({out_bank, out_last}), 172'({e.bank, e.last}));
        if (io_out_ready) void'(exp_q.pop_front());
      end
      if (io_flush || reset) exp_q.delete();
    end
  end

  // One clock of stimulus; an accepted update contributes its two beats to the scoreboard.
  task automatic cyc();
    logic acc;
    @(negedge clock);
    acc = io_in_valid && io_in_ready && !reset;
    @(posedge clock);
    if (acc) begin
      exp_q.push_back('{pl: w_in_pl, meta: in_m0, bank: 1'b0, last: 1'b0});
      exp_q.push_back('{pl: w_in_pl, meta: in_m1, bank: 1'b1, last: 1'b1});
    end
    last_acc = acc;
    #1;
  endtask

  task automatic rand_bits();
    in_is_mis = 1'($urandom); in_is_rep = 1'($urandom);
    in_btb = 8'($urandom); in_pc = {8'($urandom), $urandom}; in_brm = 8'($urandom);
    in_cv = 1'($urandom); in_cb = 3'($urandom);
    in_ct = 1'($urandom); in_cm = 1'($urandom); in_cbr = 1'($urandom); in_cj = 1'($urandom);
    in_gh = {$urandom, $urandom}; in_gnt = 1'($urandom); in_gt = 1'($urandom);
    in_tgt = {8'($urandom), $urandom};
    in_m0 = {24'($urandom), $urandom, $urandom, $urandom};
    in_m1 = {24'($urandom), $urandom, $urandom, $urandom};
  endtask

  task automatic drain();
    int k;
    io_in_valid = 1'b0; io_out_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin cyc(); k++; end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout actual=%0d beats left required=0", exp_q.size());
    end
    cyc();
  endtask

  initial begin
    int k;
    reset = 1'b1; io_flush = 1'b0; io_in_valid = 1'b0; io_out_ready = 1'b0;
    rand_bits();
    cyc(); cyc();
    reset = 1'b0;
    mon_en = 1'b1;
    cyc();

    // Single update with fixed pc, sink always ready.
    rand_bits(); in_pc = 40'h0080000040; io_in_valid = 1'b1; io_out_ready = 1'b1;
    cyc();
    io_in_valid = 1'b0;
    repeat (4) cyc();

    // Backpressure: two fill the FIFO, the third waits until drained.
    io_out_ready = 1'b0;
    rand_bits(); io_in_valid = 1'b1; cyc();
    rand_bits(); cyc();
    rand_bits(); repeat (3) cyc();
    io_out_ready = 1'b1;
    k = 0;
    last_acc = 1'b0;
    while (!last_acc && k < 10) begin cyc(); k++; end
    total++;
    if (!last_acc) begin bad++; $display("FAIL third_accept_timeout actual=0 required=1"); end
    drain();

    // Stall after the bank-0 handshake.
    rand_bits(); io_in_valid = 1'b1; io_out_ready = 1'b1; cyc();
    io_in_valid = 1'b0; cyc();
    io_out_ready = 1'b0; repeat (5) cyc();
    drain();

    // Enqueue coinciding with the bank-1 pop.
    rand_bits(); io_in_valid = 1'b1; io_out_ready = 1'b1; cyc();
    io_in_valid = 1'b0; cyc();
    rand_bits(); io_in_valid = 1'b1; cyc();
    drain();

    // Flush with two buffered and the head half-sent.
    io_out_ready = 1'b0;
    rand_bits(); io_in_valid = 1'b1; cyc();
    rand_bits(); cyc();
    io_in_valid = 1'b0; io_out_ready = 1'b1; cyc();
    io_out_ready = 1'b0; io_flush = 1'b1; cyc();
    io_flush = 1'b0; cyc();
    rand_bits(); io_in_valid = 1'b1; io_out_ready = 1'b1; cyc();
    drain();

    // Reset with the FIFO full.
    io_out_ready = 1'b0;
    rand_bits(); io_in_valid = 1'b1; cyc();
    rand_bits(); cyc();
    io_in_valid = 1'b0; io_out_ready = 1'b1; cyc();
    io_out_ready = 1'b0; reset = 1'b1; cyc();
    reset = 1'b0; io_out_ready = 1'b1; repeat (6) cyc();

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      rand_bits();
      reset        = ($urandom_range(0, 96) == 0);
      io_flush     = ($urandom_range(0, 39) == 0);
      io_in_valid  = !reset && ($urandom_range(0, 3) != 0);
      io_out_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end
    reset = 1'b0; io_flush = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
